// File: rtl/pic_bus_interface.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pic_bus_interface
// Description : Clocked PIC data bus buffer. Synchronises CS/RD/WR/A0, queues
//               CPU writes in a FIFO and serves reads by request/latch.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_bus_interface #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cs_n,
    input  logic                          rd_n,
    input  logic                          wr_n,
    input  logic                          a0,
    inout  wire  [DATA_WIDTH-1:0]         data_bus,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_a0,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic                          rd_req,
    output logic                          rd_a0,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          protocol_err,
    input  logic                          clr_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_full    = CNT_W'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic [SYNC_STAGES-1:0] r_a0_sync;

    logic                  r_wr_act_d;
    logic                  r_rd_act_d;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_a0;

    logic [DATA_WIDTH-1:0] r_mem    [FIFO_DEPTH];
    logic                  r_mem_a0 [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  r_rd_req;
    logic                  r_rd_a0;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_out_reg;
    logic                  r_overflow;
    logic                  r_protocol_err;

    logic                  w_a0_s;
    logic                  w_sel;
    logic                  w_wr_act;
    logic                  w_rd_act;
    logic                  w_conflict;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push_ok;
    logic                  w_drop;
    logic                  w_rd_rise;
    logic                  w_bus_oe;
    logic [CNT_W-1:0]      w_count_next;

    // Strobes reset to their inactive level so nothing fires while leaving reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync <= '1;
            r_rd_sync <= '1;
            r_wr_sync <= '1;
            r_a0_sync <= '0;
        end else begin
            r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], rd_n};
            r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], wr_n};
            r_a0_sync <= {r_a0_sync[SYNC_STAGES-2:0], a0};
        end
    end

    assign w_a0_s     = r_a0_sync[SYNC_STAGES-1];
    assign w_sel      = ~r_cs_sync[SYNC_STAGES-1];
    assign w_wr_act   = w_sel & ~r_wr_sync[SYNC_STAGES-1];
    assign w_rd_act   = w_sel & ~r_rd_sync[SYNC_STAGES-1];
    assign w_conflict = w_wr_act & w_rd_act;

    assign w_push    = r_wr_act_d & ~w_wr_act;
    assign w_pop     = (r_count != '0) & wr_ready;
    assign w_full    = (r_count == c_full);
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_rd_rise = w_rd_act & ~r_rd_act_d & ~w_conflict;

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop) begin
            w_count_next = r_count + c_cnt_one;
        end else if (!w_push_ok && w_pop) begin
            w_count_next = r_count - c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_act_d     <= 1'b0;
            r_rd_act_d     <= 1'b0;
            r_hold_data    <= '0;
            r_hold_a0      <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_rd_req       <= 1'b0;
            r_rd_a0        <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_out_reg      <= '0;
            r_overflow     <= 1'b0;
            r_protocol_err <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i]    <= '0;
                r_mem_a0[i] <= 1'b0;
            end
        end else begin
            r_wr_act_d <= w_wr_act;
            r_rd_act_d <= w_rd_act;

            // Keep the last clean write sample; a conflicting cycle is not trusted
            if (w_wr_act && !w_conflict) begin
                r_hold_data <= data_bus;
                r_hold_a0   <= w_a0_s;
            end

            if (w_push_ok) begin
                r_mem[r_wr_ptr]    <= r_hold_data;
                r_mem_a0[r_wr_ptr] <= r_hold_a0;
                r_wr_ptr           <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= w_count_next;

            r_rd_req <= w_rd_rise;
            if (w_rd_rise) begin
                r_rd_a0 <= w_a0_s;
            end

            if (!w_rd_act) begin
                r_rd_valid <= 1'b0;
            end else if (r_rd_req) begin
                r_out_reg  <= rd_data;
                r_rd_valid <= 1'b1;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end

            if (w_conflict) begin
                r_protocol_err <= 1'b1;
            end else if (clr_err) begin
                r_protocol_err <= 1'b0;
            end
        end
    end

    // Combinational rd_act gating releases the bus in the cycle the read ends
    assign w_bus_oe = w_rd_act & ~w_wr_act & r_rd_valid;
    assign data_bus = w_bus_oe ? r_out_reg : {DATA_WIDTH{1'bz}};

    assign wr_data      = r_mem[r_rd_ptr];
    assign wr_a0        = r_mem_a0[r_rd_ptr];
    assign wr_valid     = (r_count != '0);
    assign rd_req       = r_rd_req;
    assign rd_a0        = r_rd_a0;
    assign fifo_count   = r_count;
    assign overflow     = r_overflow;
    assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_pic_bus_interface.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pic_bus_interface
// Description : Self-checking bench for pic_bus_interface with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_bus_interface;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam logic [DW-1:0] c_idle = 8'hFF;  // undriven bus floats high

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
    logic          wr_ready = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] rd_data = '0, bus_val = '0;
    logic          bus_drv = 1'b0;

    tri1  [DW-1:0] data_bus;
    assign data_bus = bus_drv ? bus_val : {DW{1'bz}};

    wire [DW-1:0]            wr_data;
    wire                     wr_a0, wr_valid, rd_req, rd_a0, overflow, protocol_err;
    wire [$clog2(DEPTH):0]   fifo_count;

    pic_bus_interface #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
        .data_bus(data_bus), .wr_data(wr_data), .wr_a0(wr_a0), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_req(rd_req), .rd_a0(rd_a0), .rd_data(rd_data),
        .fifo_count(fifo_count), .overflow(overflow), .protocol_err(protocol_err),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    logic [DW:0] model_q[$];   // {a0, data}
    logic        model_ovf = 1'b0;

    typedef struct {
        logic [DW-1:0] d;
        logic          a;
        int            exp_cnt;
        logic          exp_ovf;
    } wvec_t;
    wvec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(fifo_count), 32'(model_q.size()));
        chk({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
        chk({tag, "_valid"}, 32'(wr_valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            chk({tag, "_head"}, 32'({wr_a0, wr_data}), 32'(model_q[0]));
        end
    endtask

    task automatic do_write(input logic [DW-1:0] d, input logic av, input bit pop_at_push);
        cs_n = 1'b0; a0 = av; bus_val = d; bus_drv = 1'b1; wr_n = 1'b0;
        repeat (4) tick();
        wr_n = 1'b1;
        tick();
        tick();
        if (pop_at_push) begin
            chk("pp_head", 32'({wr_a0, wr_data}), 32'(model_q[0]));
            wr_ready = 1'b1;
        end
        tick();
        wr_ready = 1'b0;
        if (pop_at_push && model_q.size() != 0) begin
            void'(model_q.pop_front());
            model_q.push_back({av, d});
        end else if (model_q.size() < DEPTH) begin
            model_q.push_back({av, d});
        end else begin
            model_ovf = 1'b1;
        end
        check_state("wr");
        cs_n = 1'b1; bus_drv = 1'b0;
        tick();
    endtask

    task automatic do_pop();
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
        check_state("pop");
    endtask

    task automatic do_read(input logic av, input logic [DW-1:0] rv);
        int pulses = 0;
        cs_n = 1'b0; a0 = av; rd_data = rv; rd_n = 1'b0;
        for (int i = 1; i <= SS + 2; i++) begin
            if (i < SS + 2) chk("rd_bus_pre", 32'(data_bus), 32'(c_idle));
            tick();
            if (rd_req) begin
                pulses++;
                chk("rd_a0", 32'(rd_a0), 32'(av));
            end
        end
        chk("rd_bus", 32'(data_bus), 32'(rv));
        rd_data = ~rv;
        tick();
        if (rd_req) pulses++;
        chk("rd_bus_hold", 32'(data_bus), 32'(rv));
        rd_n = 1'b1;
        tick();
        if (rd_req) pulses++;
        chk("rd_bus_tail", 32'(data_bus), 32'(rv));
        tick();
        chk("rd_bus_release", 32'(data_bus), 32'(c_idle));
        chk("rd_req_pulses", 32'(pulses), 32'd1);
        cs_n = 1'b1;
        tick();
    endtask

    initial begin
        tbl[0] = '{8'h01, 1'b0, 1, 1'b0};
        tbl[1] = '{8'h02, 1'b1, 2, 1'b0};
        tbl[2] = '{8'h03, 1'b0, 3, 1'b0};
        tbl[3] = '{8'h04, 1'b1, 4, 1'b0};
        tbl[4] = '{8'h05, 1'b0, 4, 1'b1};

        repeat (3) tick();
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_valid", 32'(wr_valid), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_rd_a0", 32'(rd_a0), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_perr", 32'(protocol_err), 32'd0);
        chk("rst_bus", 32'(data_bus), 32'(c_idle));
        rst_n = 1'b1;
        repeat (2) tick();

        // Single write then pop
        do_write(8'h5A, 1'b1, 1'b0);
        chk("sw_data", 32'(wr_data), 32'h5A);
        chk("sw_a0", 32'(wr_a0), 32'd1);
        do_pop();

        // Overflow, table driven
        foreach (tbl[i]) begin
            do_write(tbl[i].d, tbl[i].a, 1'b0);
            chk("tbl_count", 32'(fifo_count), 32'(tbl[i].exp_cnt));
            chk("tbl_ovf", 32'(overflow), 32'(tbl[i].exp_ovf));
        end
        repeat (4) do_pop();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        model_ovf = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Push and pop together while full
        for (int i = 0; i < DEPTH; i++) do_write(8'h10 + 8'(i), 1'(i), 1'b0);
        do_write(8'h99, 1'b1, 1'b1);
        chk("pp_count", 32'(fifo_count), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        repeat (3) do_pop();
        chk("pp_new_head", 32'(wr_data), 32'h99);
        do_pop();

        do_read(1'b0, 8'hC3);

        // Async reset while the bus is driven
        do_write(8'h33, 1'b0, 1'b0);
        cs_n = 1'b0; a0 = 1'b1; rd_data = 8'h42; rd_n = 1'b0;
        repeat (SS + 2) tick();
        chk("ar_bus_on", 32'(data_bus), 32'h42);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_bus", 32'(data_bus), 32'(c_idle));
        chk("ar_count", 32'(fifo_count), 32'd0);
        chk("ar_valid", 32'(wr_valid), 32'd0);
        chk("ar_rd_a0", 32'(rd_a0), 32'd0);
        chk("ar_rd_req", 32'(rd_req), 32'd0);
        model_q.delete();
        model_ovf = 1'b0;
        rd_n = 1'b1; cs_n = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Conflict: the pending write must carry the last clean sample
        do_write(8'h6C, 1'b1, 1'b0);
        do_pop();
        cs_n = 1'b0; a0 = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("cf_rd_req", 32'(rd_req), 32'd0);
            chk("cf_bus", 32'(data_bus), 32'(c_idle));
        end
        chk("cf_perr", 32'(protocol_err), 32'd1);
        rd_n = 1'b1; wr_n = 1'b1;
        repeat (3) tick();
        model_q.push_back({1'b1, 8'h6C});
        check_state("cf");
        cs_n = 1'b1;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("cf_perr_clr", 32'(protocol_err), 32'd0);
        do_pop();

        // Random traffic against the queue model
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0, 1: do_write(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
                2:    do_pop();
                3:    do_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)));
                default: begin
                    clr_err = 1'b1;
                    tick();
                    clr_err = 1'b0;
                    model_ovf = 1'b0;
                end
            endcase
            check_state("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pic_bus_interface.md
Name: pic_bus_interface

Overview:
Parametrised, clocked successor to the PIC's data bus buffer. It synchronises the external active-low CS/RD/WR strobes into the core clock domain and queues CPU writes, together with their A0 address bit, in a FIFO toward the control logic. CPU reads run as a request/latch handshake, and the block drives the tri-state bus only while a qualified read is active. It sits between the CPU pins and the PIC's read/write control logic and register file.

Parameters:
DATA_WIDTH, 8, width of the external data bus and of the internal data paths.
FIFO_DEPTH, 4, write FIFO entries; must be a power of two, minimum 2.
SYNC_STAGES, 2, flip-flop stages on cs_n/rd_n/wr_n/a0; minimum 2.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
cs_n  input  1  chip select, active low, asynchronous to clk
rd_n  input  1  read strobe, active low, asynchronous
wr_n  input  1  write strobe, active low, asynchronous
a0  input  1  address bit, asynchronous
data_bus  inout  DATA_WIDTH  external CPU data bus
wr_data  output  DATA_WIDTH  FIFO head data
wr_a0  output  1  FIFO head A0
wr_valid  output  1  FIFO not empty
wr_ready  input  1  consumer accepts head when high with wr_valid
rd_req  output  1  one-cycle pulse requesting read data
rd_a0  output  1  A0 captured for the current read
rd_data  input  DATA_WIDTH  read data; valid the cycle after rd_req
fifo_count  output  clog2(FIFO_DEPTH)+1  occupied entries
overflow  output  1  sticky: a write was dropped because the FIFO was full
protocol_err  output  1  sticky: RD and WR were both active while selected
clr_err  input  1  synchronous clear of overflow and protocol_err

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_count=0, wr_valid=0, rd_req=0, rd_a0=0, overflow=0, protocol_err=0, data_bus=Z, sync chains loaded to the inactive level (1 for the _n strobes, 0 for a0).
- Synchronisation: cs_n, rd_n, wr_n and a0 each pass through SYNC_STAGES flops. sel = !cs_s; wr_act = sel & !wr_s; rd_act = sel & !rd_s.
- Write capture: while wr_act, register the raw data_bus and a0_s every cycle into a holding register.
  - On the first cycle wr_act falls (1->0), push {hold_data, hold_a0} into the FIFO.
  - If CS deasserts before WR does, the write still ends on that wr_act fall edge and is pushed.
- FIFO: head shown on wr_data/wr_a0; pop when wr_valid & wr_ready. Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop: count unchanged. This holds even when full, where the pop frees the slot.
  - Push while full with no pop: entry dropped, overflow=1, FIFO contents unchanged.
  - Pop while empty: ignored.
- Read: on the rd_act rise (0->1):
  - rd_req=1 for exactly one cycle, with rd_a0=a0_s.
  - The next cycle latches rd_data into out_reg and sets rd_valid_int.
  - The bus drives out_reg while rd_act & rd_valid_int. Otherwise it is Z.
  - When rd_act falls, rd_valid_int clears and the bus returns to Z in that same cycle.
  - Latency: the bus is driven SYNC_STAGES+2 clk cycles after RD falls.
- Both rd_act and wr_act high in the same cycle: protocol_err=1; no new rd_req; the write hold register is not updated; the bus stays Z. Any write in progress is still pushed on the wr_act fall.
- clr_err clears both sticky flags the next cycle. If a set event occurs in the same cycle, the set wins.
- Reset mid-operation: any transaction in flight is discarded, FIFO contents are lost, and the bus goes Z immediately (asynchronously).

Test Plan:
- Single write: cs_n=0, a0=1, data 0x5A, wr_n low for 4 clk then high -> one SYNC_STAGES+1 cycles later wr_valid=1, wr_data=0x5A, wr_a0=1, fifo_count=1; wr_ready=1 -> count 0 next cycle.
- Overflow: wr_ready=0, five writes 0x01..0x05 (depth 4) -> fifo_count=4, overflow=1; pops yield 0x01..0x04 in order; clr_err -> overflow=0.
- Read: cs_n=0, a0=0, rd_n low, rd_data=0xC3 -> exactly one rd_req pulse with rd_a0=0; data_bus=0xC3 SYNC_STAGES+2 cycles after RD falls; Z in the cycle rd_act drops.
- Push/pop at full: FIFO full with wr_ready=1 while a write ends -> count stays 4, no overflow, and the new data appears after 3 further pops.
- Conflict: rd_n and wr_n low together with cs_n=0 -> protocol_err=1, no rd_req, bus Z throughout.
- Async reset mid-read: assert rst_n=0 while the bus is driven -> data_bus=Z and all outputs at reset values without waiting for a clock edge.
